calc_unit_multibit: RTL and testbench

- Generalised binary-weight × multi-bit-activation MAC lane for the quantised conv engine.
- Each accepted beat carries IN_BITS activation bit-planes of WORD_WIDTH channels plus one WORD_WIDTH kernel word (bit 1 = +1, bit 0 = −1).
- Computes the signed dot product via XNOR-popcount and accumulates it across input-channel beats.
- Emits one saturated result per first..last group on a valid/ready output with full backpressure.

---
 rtl/calc_unit_multibit.sv | 134 +++++++++++++
 tb/tb_calc_unit_multibit.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_unit_multibit.sv
// Binary-weight x multi-bit-activation MAC lane.
// Two-stage XNOR-popcount dot product with saturating group accumulator.
module calc_unit_multibit #(
  parameter int WORD_WIDTH = 32,
  parameter int IN_BITS    = 2,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic [IN_BITS*WORD_WIDTH-1:0] in_data,
  input  logic [WORD_WIDTH-1:0]         kn_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          out_ovf
);

  localparam int CW = $clog2(WORD_WIDTH + 1);
  localparam int TW = CW + IN_BITS + 2;
  localparam int SW = ((OUT_WIDTH > TW) ? OUT_WIDTH : TW) + 1;

  localparam logic signed [SW-1:0] KMUL =
    SW'((1 << IN_BITS) - 1);
  localparam logic signed [SW-1:0] MAXV =
    {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  function automatic logic [CW-1:0] popcnt(
    input logic [WORD_WIDTH-1:0] v
  );
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WORD_WIDTH; i++)
      c = c + CW'(v[i]);
    return c;
  endfunction

  logic advance;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  logic [IN_BITS-1:0][CW-1:0] p_d;
  logic [CW-1:0]              n_d;

  always_comb begin
    p_d = '0;
    for (int b = 0; b < IN_BITS; b++)
      p_d[b] = popcnt(~(in_data[b*WORD_WIDTH +: WORD_WIDTH]
                        ^ kn_data));
    n_d = popcnt(~kn_data);
  end

  logic                       s1_valid;
  logic                       s1_first;
  logic                       s1_last;
  logic [IN_BITS-1:0][CW-1:0] s1_p;
  logic [CW-1:0]              s1_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_p     <= '0;
      s1_n     <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_first <= in_first;
      s1_last  <= in_last;
      s1_p     <= p_d;
      s1_n     <= n_d;
    end
  end

  logic [OUT_WIDTH-1:0]   acc;
  logic                   ovf;
  logic signed [SW-1:0]   term;
  logic signed [SW-1:0]   base;
  logic signed [SW-1:0]   sum;
  logic [OUT_WIDTH-1:0]   res;
  logic                   sat_hit;
  logic                   ovf_n;

  // Weighted plane sum minus the all-(-1) offset gives the signed dot product
  always_comb begin
    term = '0;
    for (int b = 0; b < IN_BITS; b++)
      term = term + ($signed(SW'(s1_p[b])) <<< b);
    term = term - $signed(SW'(s1_n)) * KMUL;
    base = s1_first ? '0
         : {{(SW-OUT_WIDTH){acc[OUT_WIDTH-1]}}, acc};
    sum  = base + term;
    sat_hit = 1'b0;
    res     = sum[OUT_WIDTH-1:0];
    if (sum > MAXV) begin
      sat_hit = 1'b1;
      res     = MAXV[OUT_WIDTH-1:0];
    end else if (sum < MINV) begin
      sat_hit = 1'b1;
      res     = MINV[OUT_WIDTH-1:0];
    end
    ovf_n = (s1_first ? 1'b0 : ovf) | sat_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (advance) begin
      out_valid <= 1'b0;
      if (s1_valid) begin
        if (s1_last) begin
          acc       <= '0;
          ovf       <= 1'b0;
          out_valid <= 1'b1;
          out_data  <= res;
          out_ovf   <= ovf_n;
        end else begin
          acc <= res;
          ovf <= ovf_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_unit_multibit.sv
// Randomised bench for calc_unit_multibit against a dot-product model.
// Two lanes run in parallel: 32-bit and 8-bit result width.
module tb_calc_unit_multibit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_first;
  logic        in_last;
  logic [63:0] in_data;
  logic [31:0] kn_data;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [31:0] out_data_a;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [7:0]  out_data_b;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
  localparam logic [63:0] A1   = {32'h0, ONES};
  localparam logic [63:0] A3   = {ONES, ONES};

  always #5 clk = ~clk;

  calc_unit_multibit dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .in_first(in_first), .in_last(in_last),
    .in_data(in_data), .kn_data(kn_data),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_ovf(out_ovf_a)
  );

  calc_unit_multibit #(.OUT_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_first(in_first), .in_last(in_last),
    .in_data(in_data), .kn_data(kn_data),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_ovf(out_ovf_b)
  );

  // Reference: signed dot product of activations with +/-1 weights
  function automatic longint dot(
    input logic [63:0] d, input logic [31:0] k
  );
    longint s = 0;
    for (int i = 0; i < 32; i++) begin
      int act;
      act = int'(d[i]) + 2 * int'(d[32+i]);
      s += k[i] ? act : -act;
    end
    return s;
  endfunction

  longint acc_a = 0, acc_b = 0;
  bit     ovf_a = 0, ovf_b = 0;
  logic [32:0] exp_a[$];
  logic [8:0]  exp_b[$];

  localparam longint MAX_A = (longint'(1) << 31) - 1;
  localparam longint MIN_A = -(longint'(1) << 31);
  localparam longint MAX_B = 127;
  localparam longint MIN_B = -128;

  always @(negedge clk) begin
    if (rst) begin
      acc_a = 0; ovf_a = 0;
      acc_b = 0; ovf_b = 0;
      exp_a.delete();
      exp_b.delete();
    end else begin
      if (out_valid_a && out_ready) begin
        vectors++;
        if (exp_a.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_a: unexpected result %h",
                   out_data_a);
        end else begin
          logic [32:0] e;
          e = exp_a.pop_front();
          if ({out_ovf_a, out_data_a} !== e) begin
            miscompares++;
            $display("FAIL scoreboard_a: got ovf=%b data=%0d want ovf=%b data=%0d",
                     out_ovf_a, $signed(out_data_a), e[32], $signed(e[31:0]));
          end
        end
      end
      if (out_valid_b && out_ready) begin
        vectors++;
        if (exp_b.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_b: unexpected result %h",
                   out_data_b);
        end else begin
          logic [8:0] e;
          e = exp_b.pop_front();
          if ({out_ovf_b, out_data_b} !== e) begin
            miscompares++;
            $display("FAIL scoreboard_b: got ovf=%b data=%0d want ovf=%b data=%0d",
                     out_ovf_b, $signed(out_data_b), e[8], $signed(e[7:0]));
          end
        end
      end
      if (in_valid && in_ready_a) begin
        longint t;
        t = dot(in_data, kn_data);
        if (in_first) begin
          acc_a = 0; ovf_a = 0;
          acc_b = 0; ovf_b = 0;
        end
        acc_a += t;
        if (acc_a > MAX_A) begin acc_a = MAX_A; ovf_a = 1; end
        if (acc_a < MIN_A) begin acc_a = MIN_A; ovf_a = 1; end
        acc_b += t;
        if (acc_b > MAX_B) begin acc_b = MAX_B; ovf_b = 1; end
        if (acc_b < MIN_B) begin acc_b = MIN_B; ovf_b = 1; end
        if (in_last) begin
          exp_a.push_back({ovf_a, acc_a[31:0]});
          exp_b.push_back({ovf_b, acc_b[7:0]});
          acc_a = 0; ovf_a = 0;
          acc_b = 0; ovf_b = 0;
        end
      end
    end
  end

  // Presents one beat and returns 1ns after the edge that accepts it
  task automatic send_beat(
    input bit f, input bit l,
    input logic [63:0] d, input logic [31:0] k
  );
    int n = 0;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    in_data  = d;
    kn_data  = k;
    @(negedge clk);
    while (!in_ready_a && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready_a) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready=%b want 1", in_ready_a);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 300) begin
      n++;
      @(posedge clk);
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid_a !== 1'b0 || out_data_a !== 32'd0
        || out_ovf_a !== 1'b0 || out_valid_b !== 1'b0
        || out_data_b !== 8'd0 || out_ovf_b !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b data=%h ovf=%b want 0/0/0",
               out_valid_a, out_data_a, out_ovf_a);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready_a !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: in_ready=%b want 1", in_ready_a);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send_beat(1, 1, A1, ONES);
    vectors++;
    if (out_valid_a !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: out_valid=%b want 0", out_valid_a);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid_a !== 1'b1 || out_data_a !== 32'd32
        || out_ovf_a !== 1'b0 || out_data_b !== 8'd32) begin
      miscompares++;
      $display("FAIL single_32: valid=%b data=%0d ovf=%b want 1/32/0",
               out_valid_a, $signed(out_data_a), out_ovf_a);
    end
    settle();
  endtask

  task automatic test_negative();
    send_beat(1, 1, A3, 32'h0);
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid_a !== 1'b1 || out_data_a !== -32'sd96
        || out_data_b !== 8'hA0 || out_ovf_b !== 1'b0) begin
      miscompares++;
      $display("FAIL neg_96: data=%0d b=%0d want -96",
               $signed(out_data_a), $signed(out_data_b));
    end
    send_beat(1, 0, A3, 32'h0);
    send_beat(0, 0, A3, 32'h0);
    send_beat(0, 1, A3, 32'h0);
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid_a !== 1'b1 || out_data_a !== -32'sd288
        || out_ovf_a !== 1'b0) begin
      miscompares++;
      $display("FAIL neg_288: data=%0d ovf=%b want -288/0",
               $signed(out_data_a), out_ovf_a);
    end
    vectors++;
    if (out_data_b !== 8'h80 || out_ovf_b !== 1'b1) begin
      miscompares++;
      $display("FAIL neg_sat8: data=%0d ovf=%b want -128/1",
               $signed(out_data_b), out_ovf_b);
    end
    settle();
  endtask

  task automatic test_saturate();
    send_beat(1, 0, A3, ONES);
    send_beat(0, 1, A3, ONES);
    @(posedge clk);
    #1;
    vectors++;
    if (out_data_b !== 8'h7F || out_ovf_b !== 1'b1
        || out_data_a !== 32'd192 || out_ovf_a !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_pos: b=%0d/%b a=%0d/%b want 127/1 192/0",
               $signed(out_data_b), out_ovf_b, out_data_a, out_ovf_a);
    end
    send_beat(1, 1, A1, ONES);
    @(posedge clk);
    #1;
    vectors++;
    if (out_data_b !== 8'd32 || out_ovf_b !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_clear: b=%0d/%b want 32/0",
               $signed(out_data_b), out_ovf_b);
    end
    settle();
  endtask

  task automatic test_backpressure();
    bit done = 0;
    int n = 0;
    out_ready = 1'b0;
    send_beat(1, 1, A1, ONES);
    fork
      begin
        for (int g = 0; g < 4; g++) begin
          int len;
          len = $urandom_range(1, 3);
          for (int j = 0; j < len; j++)
            send_beat(j == 0, j == len - 1,
                      {$urandom, $urandom}, $urandom);
        end
        done = 1;
      end
    join_none
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1
          || out_data_a !== 32'd32) begin
        miscompares++;
        $display("FAIL bp_hold: ready=%b valid=%b data=%0d want 0/1/32",
                 in_ready_a, out_valid_a, out_data_a);
      end
    end
    out_ready = 1'b1;
    while (!done && n < 500) begin
      n++;
      @(posedge clk);
    end
    #1;
    settle();
    vectors++;
    if (!done || exp_a.size() != 0 || exp_b.size() != 0) begin
      miscompares++;
      $display("FAIL bp_drain: done=%b pending=%0d want 1/0",
               done, exp_a.size());
    end
  endtask

  task automatic test_bubbles_restart();
    out_ready = 1'b1;
    send_beat(1, 0, A1, ONES);
    repeat (2) @(posedge clk);
    #1;
    send_beat(0, 0, A1, ONES);
    repeat (3) @(posedge clk);
    #1;
    send_beat(0, 1, A1, ONES);
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid_a !== 1'b1 || out_data_a !== 32'd96) begin
      miscompares++;
      $display("FAIL bubbles_96: valid=%b data=%0d want 1/96",
               out_valid_a, $signed(out_data_a));
    end
    send_beat(1, 0, A1, ONES);
    send_beat(0, 0, A1, ONES);
    send_beat(1, 0, A3, 32'h0);
    send_beat(0, 1, A1, ONES);
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid_a !== 1'b1 || out_data_a !== -32'sd64) begin
      miscompares++;
      $display("FAIL restart_-64: valid=%b data=%0d want 1/-64",
               out_valid_a, $signed(out_data_a));
    end
    send_beat(0, 1, A1, ONES);
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid_a !== 1'b1 || out_data_a !== 32'd32) begin
      miscompares++;
      $display("FAIL nofirst_32: valid=%b data=%0d want 1/32",
               out_valid_a, $signed(out_data_a));
    end
    settle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send_beat(1, 1, A3, 32'h0);
    send_beat(1, 0, A3, ONES);
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid_a !== 1'b0 || out_data_a !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_async: valid=%b data=%h want 0/0",
               out_valid_a, out_data_a);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid_a !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_spurious: valid=%b want 0", out_valid_a);
      end
    end
    send_beat(0, 1, A1, ONES);
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid_a !== 1'b1 || out_data_a !== 32'd32) begin
      miscompares++;
      $display("FAIL rst_fresh: valid=%b data=%0d want 1/32",
               out_valid_a, $signed(out_data_a));
    end
    settle();
  endtask

  task automatic test_random();
    bit stop = 0;
    fork
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom % 3) != 0;
        end
        out_ready = 1'b1;
      end
    join_none
    for (int g = 0; g < 40; g++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
        bit f;
        f = (j == 0) ? (($urandom % 6) != 0)
                     : (($urandom % 8) == 0);
        send_beat(f, j == len - 1,
                  {$urandom, $urandom}, $urandom);
        if (($urandom % 3) == 0)
          repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    stop = 1;
    repeat (2) @(posedge clk);
    settle();
    vectors++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      miscompares++;
      $display("FAIL random_drain: pending=%0d/%0d want 0",
               exp_a.size(), exp_b.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    kn_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_negative();
    test_saturate();
    test_backpressure();
    test_bubbles_restart();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
